ctrl_pipe_stage: RTL and testbench

- Consumer side of the decoded control bundle produced by the instruction decoder/control ROM in ID.
- Carries control fields and destination register addresses through the EX, MEM and WB pipeline registers.
- Detects RAW/load-use hazards and generates IF/ID stall and flush.
- Inserts bubbles on hazards and taken branches/jumps, and freezes the pipeline on memory wait.

---
 rtl/ctrl_pipe_pkg.sv | 24 ++
 rtl/ctrl_pipe_stage_hazard.sv | 84 ++++++++
 rtl/ctrl_pipe_stage.sv | 149 ++++++++++++++
 tb/tb_ctrl_pipe_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Control-bundle layout, forward-select encodings and the bubble constant shared by the
// control pipeline and its hazard unit.
package ctrl_pipe_pkg;

    localparam int ALUOP_W = 4;
    localparam int CTRL_W  = ALUOP_W + 9;

    localparam int CTRL_JUMP       = 0;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_RWSEL      = 2;
    localparam int CTRL_ALUSRC_LSB = 3;
    localparam int CTRL_ALUOP_LSB  = 5;
    localparam int CTRL_MEMWRITE   = CTRL_ALUOP_LSB + ALUOP_W;
    localparam int CTRL_MEMREAD    = CTRL_MEMWRITE + 1;
    localparam int CTRL_MEMTOREG   = CTRL_MEMWRITE + 2;
    localparam int CTRL_REGWRITE   = CTRL_MEMWRITE + 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_stage_hazard.sv
// Combinational RAW/load-use detection, IF/ID stall/flush and EX bubble request; zero latency.
// CTRL_PIPE_FWD_EN adds MEM/WB forward selects and narrows stalls to load-use only.
module ctrl_hazard_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  rst,
    input  logic                  mem_wait,
    input  logic                  ex_taken,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
`ifdef CTRL_PIPE_FWD_EN
    input  logic                  ex_memread,
    input  logic                  wb_valid,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`endif
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  ex_bubble
);

    // A producer only counts if it really writes a nonzero register and ID is real.
    logic ex_wr;
    logic mem_wr;
    logic ex_hit;
    logic mem_hit_a;
    logic mem_hit_b;
    logic raw_stall;

    assign ex_wr     = id_valid && ex_valid && ex_regwrite && (ex_rd != '0);
    assign mem_wr    = id_valid && mem_valid && mem_regwrite && (mem_rd != '0);
    assign ex_hit    = ex_wr && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_hit_a = mem_wr && (mem_rd == id_rs1);
    assign mem_hit_b = mem_wr && (mem_rd == id_rs2);

`ifdef CTRL_PIPE_FWD_EN
    logic wb_wr;

    assign wb_wr     = id_valid && wb_valid && wb_regwrite && (wb_rd != '0);
    assign raw_stall = ex_hit && ex_memread;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            if (mem_hit_a)                      fwd_a = FWD_MEM;
            else if (wb_wr && wb_rd == id_rs1)  fwd_a = FWD_WB;
            if (mem_hit_b)                      fwd_b = FWD_MEM;
            else if (wb_wr && wb_rd == id_rs2)  fwd_b = FWD_WB;
        end
    end
`else
    assign raw_stall = ex_hit || mem_hit_a || mem_hit_b;
`endif

    always_comb begin
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        ex_bubble   = 1'b0;
        if (rst) begin
            stall_if_id = 1'b0;
        end else if (mem_wait) begin
            stall_if_id = 1'b1;
        end else if (ex_taken) begin
            flush_if_id = 1'b1;
            ex_bubble   = 1'b1;
        end else if (raw_stall) begin
            stall_if_id = 1'b1;
            ex_bubble   = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// EX/MEM/WB control pipeline registers (1 cycle per stage) with bubble insertion on hazard or
// taken branch and a full freeze on mem_wait; CTRL_PIPE_FWD_EN exposes fwd_a/fwd_b.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_taken,
    input  logic                  mem_wait,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_valid,
    output logic [CTRL_W-1:0]     mem_ctrl,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_valid,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic                  wb_rwsel,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall_if_id,
`ifdef CTRL_PIPE_FWD_EN
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`endif
    output logic                  flush_if_id
);

    logic                  ex_valid_q,    ex_valid_d;
    logic [CTRL_W-1:0]     ex_ctrl_q,     ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,       ex_rd_d;
    logic                  mem_valid_q,   mem_valid_d;
    logic [CTRL_W-1:0]     mem_ctrl_q,    mem_ctrl_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,      mem_rd_d;
    logic                  wb_valid_q,    wb_valid_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic                  wb_rwsel_q,    wb_rwsel_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,       wb_rd_d;
    logic                  ex_bubble;

    ctrl_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .rst          (rst),
        .mem_wait     (mem_wait),
        .ex_taken     (ex_taken),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_valid     (ex_valid_q),
        .ex_regwrite  (ex_ctrl_q[CTRL_REGWRITE]),
        .ex_rd        (ex_rd_q),
        .mem_valid    (mem_valid_q),
        .mem_regwrite (mem_ctrl_q[CTRL_REGWRITE]),
        .mem_rd       (mem_rd_q),
`ifdef CTRL_PIPE_FWD_EN
        .ex_memread   (ex_ctrl_q[CTRL_MEMREAD]),
        .wb_valid     (wb_valid_q),
        .wb_regwrite  (wb_regwrite_q),
        .wb_rd        (wb_rd_q),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
`endif
        .stall_if_id  (stall_if_id),
        .flush_if_id  (flush_if_id),
        .ex_bubble    (ex_bubble)
    );

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_rd_d       = ex_rd_q;
        mem_valid_d   = mem_valid_q;
        mem_ctrl_d    = mem_ctrl_q;
        mem_rd_d      = mem_rd_q;
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rwsel_d    = wb_rwsel_q;
        wb_rd_d       = wb_rd_q;
        if (!mem_wait) begin
            if (ex_bubble) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = BUBBLE;
                ex_rd_d    = '0;
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? id_ctrl : BUBBLE;
                ex_rd_d    = id_rd;
            end
            mem_valid_d   = ex_valid_q;
            mem_ctrl_d    = ex_ctrl_q;
            mem_rd_d      = ex_rd_q;
            // WB keeps only the fields the writeback path consumes.
            wb_valid_d    = mem_valid_q;
            wb_regwrite_d = mem_ctrl_q[CTRL_REGWRITE];
            wb_memtoreg_d = mem_ctrl_q[CTRL_MEMTOREG];
            wb_rwsel_d    = mem_ctrl_q[CTRL_RWSEL];
            wb_rd_d       = mem_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= BUBBLE;
            ex_rd_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_ctrl_q    <= BUBBLE;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rwsel_q    <= 1'b0;
            wb_rd_q       <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rd_q       <= ex_rd_d;
            mem_valid_q   <= mem_valid_d;
            mem_ctrl_q    <= mem_ctrl_d;
            mem_rd_q      <= mem_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rwsel_q    <= wb_rwsel_d;
            wb_rd_q       <= wb_rd_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_rd       = ex_rd_q;
    assign mem_valid   = mem_valid_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign mem_rd      = mem_rd_q;
    assign wb_regwrite = wb_valid_q && wb_regwrite_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign wb_rwsel    = wb_rwsel_q;
    assign wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: directed vector table, hand sequences and a random run against a
// stage-array reference model; build with CTRL_PIPE_FWD_EN to cover the forwarding variant.
module tb_ctrl_pipe_stage;

    localparam logic [12:0] C_RW    = 13'h1000;
    localparam logic [12:0] C_MTR   = 13'h0800;
    localparam logic [12:0] C_MR    = 13'h0400;
    localparam logic [12:0] C_MW    = 13'h0200;
    localparam logic [12:0] C_ALU   = 13'h0060;
    localparam logic [12:0] C_RWSEL = 13'h0004;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_taken, mem_wait;
    logic [12:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [12:0] ex_ctrl, mem_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_valid, mem_valid, wb_regwrite, wb_memtoreg, wb_rwsel;
    logic        stall_if_id, flush_if_id;
`ifdef CTRL_PIPE_FWD_EN
    logic [1:0]  fwd_a, fwd_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_taken    (ex_taken),
        .mem_wait    (mem_wait),
        .ex_ctrl     (ex_ctrl),
        .ex_rd       (ex_rd),
        .ex_valid    (ex_valid),
        .mem_ctrl    (mem_ctrl),
        .mem_rd      (mem_rd),
        .mem_valid   (mem_valid),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_rwsel    (wb_rwsel),
        .wb_rd       (wb_rd),
        .stall_if_id (stall_if_id),
`ifdef CTRL_PIPE_FWD_EN
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
`endif
        .flush_if_id (flush_if_id)
    );

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB; an instruction moves one slot per advance.
    typedef struct packed {
        logic        v;
        logic [12:0] c;
        logic [4:0]  rd;
    } stage_t;
    stage_t m [3];

    typedef struct packed {
        logic        v;
        logic [12:0] c;
        logic [4:0]  a, b, d;
        logic        tk;
        logic        e_stall, e_flush;
        logic [1:0]  e_fa, e_fb;
        logic        e_exv;
        logic [4:0]  e_exrd;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic produces(int s, logic [4:0] r);
        return id_valid && m[s].v && m[s].c[12] && (m[s].rd != 5'd0) && (m[s].rd == r);
    endfunction

    function automatic logic needs_stall();
        logic ex_dep, mem_dep;
        ex_dep  = produces(0, id_rs1) || produces(0, id_rs2);
        mem_dep = produces(1, id_rs1) || produces(1, id_rs2);
`ifdef CTRL_PIPE_FWD_EN
        return ex_dep && m[0].c[10];
`else
        return ex_dep || mem_dep;
`endif
    endfunction

`ifdef CTRL_PIPE_FWD_EN
    function automatic logic [1:0] model_fwd(logic [4:0] r);
        if (produces(1, r)) return 2'b01;
        if (produces(2, r)) return 2'b10;
        return 2'b00;
    endfunction
`endif

    task automatic drive(input logic r, input logic v, input logic [12:0] c, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic tk, input logic w);
        @(negedge clk);
        rst = r; id_valid = v; id_ctrl = c; id_rs1 = a; id_rs2 = b; id_rd = d;
        ex_taken = tk; mem_wait = w;
        #1;
        chk("stall", stall_if_id, r ? 1'b0 : (w ? 1'b1 : (tk ? 1'b0 : needs_stall())));
        chk("flush", flush_if_id, !r && !w && tk);
`ifdef CTRL_PIPE_FWD_EN
        chk("fwd_a", fwd_a, r ? 2'b00 : model_fwd(id_rs1));
        chk("fwd_b", fwd_b, r ? 2'b00 : model_fwd(id_rs2));
`endif
    endtask

    task automatic tick();
        logic bubble;
        bubble = ex_taken || needs_stall();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) m[i] = '0;
        end else if (!mem_wait) begin
            m[2] = m[1];
            m[1] = m[0];
            m[0] = bubble ? stage_t'('0) : stage_t'({id_valid, id_valid ? id_ctrl : 13'h0, id_rd});
        end
        chk("ex_valid", ex_valid, m[0].v);
        chk("ex_ctrl", ex_ctrl, m[0].c);
        chk("ex_rd", ex_rd, m[0].rd);
        chk("mem_valid", mem_valid, m[1].v);
        chk("mem_ctrl", mem_ctrl, m[1].c);
        chk("mem_rd", mem_rd, m[1].rd);
        chk("wb_regwrite", wb_regwrite, m[2].v && m[2].c[12]);
        chk("wb_memtoreg", wb_memtoreg, m[2].c[11]);
        chk("wb_rwsel", wb_rwsel, m[2].c[2]);
        chk("wb_rd", wb_rd, m[2].rd);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '0;
        rst = 1'b1; id_valid = 1'b0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        ex_taken = 1'b0; mem_wait = 1'b0;

`ifdef CTRL_PIPE_FWD_EN
        tbl[0] = '{1'b1, C_RW | C_MR | C_MTR, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd7};
        tbl[1] = '{1'b1, C_RW, 5'd3, 5'd7, 5'd8, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
        tbl[2] = '{1'b1, C_RW, 5'd3, 5'd7, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 5'd8};
        tbl[3] = '{1'b1, C_RW, 5'd8, 5'd7, 5'd12, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 5'd12};
`else
        tbl[0] = '{1'b1, C_RW, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd5};
        tbl[1] = '{1'b1, C_RW, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
        tbl[2] = '{1'b1, C_RW, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
        tbl[3] = '{1'b1, C_RW, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd6};
`endif
        tbl[4] = '{1'b1, C_RW, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd9};
        tbl[5] = '{1'b1, C_RW, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0};
        tbl[6] = '{1'b1, C_RW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd0};
        tbl[7] = '{1'b1, C_RW, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11};

        // Reset state, with mem_wait asserted to show stall is still forced low.
        drive(1'b1, 1'b0, 13'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 13'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_wb_regwrite", wb_regwrite, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].tk, 1'b0);
            chk($sformatf("tbl%0d_stall", i), stall_if_id, tbl[i].e_stall);
            chk($sformatf("tbl%0d_flush", i), flush_if_id, tbl[i].e_flush);
`ifdef CTRL_PIPE_FWD_EN
            chk($sformatf("tbl%0d_fwd_a", i), fwd_a, tbl[i].e_fa);
            chk($sformatf("tbl%0d_fwd_b", i), fwd_b, tbl[i].e_fb);
`endif
            tick();
            chk($sformatf("tbl%0d_ex_valid", i), ex_valid, tbl[i].e_exv);
            chk($sformatf("tbl%0d_ex_rd", i), ex_rd, tbl[i].e_exrd);
        end

        // Freeze for 4 cycles with a store in MEM and a writer in WB.
        drive(1'b1, 1'b0, 13'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, C_RW | C_MTR, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, C_MW | C_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, C_RW | C_RWSEL, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, C_RW, 5'd0, 5'd0, 5'd13, 1'b0, 1'b1);
            chk("wait_stall", stall_if_id, 1'b1);
            tick();
            chk("wait_mem_ctrl", mem_ctrl, C_MW | C_ALU);
            chk("wait_ex_ctrl", ex_ctrl, C_RW | C_RWSEL);
            chk("wait_ex_rd", ex_rd, 5'd4);
            chk("wait_wb_regwrite", wb_regwrite, 1'b1);
            chk("wait_wb_rd", wb_rd, 5'd3);
        end
        drive(1'b0, 1'b1, C_RW, 5'd0, 5'd0, 5'd13, 1'b0, 1'b0);
        tick();
        chk("release_mem_ctrl", mem_ctrl, C_RW | C_RWSEL);
        chk("release_ex_rd", ex_rd, 5'd13);
        chk("release_wb_regwrite", wb_regwrite, 1'b0);

        // Random traffic on a small register window so dependences are frequent.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 13'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            tick();
        end

        // Reset held 3 cycles mid-stream, then the first instruction after release.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, C_RW, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
            chk("midrst_stall", stall_if_id, 1'b0);
            chk("midrst_flush", flush_if_id, 1'b0);
            tick();
            chk("midrst_ex_valid", ex_valid, 1'b0);
            chk("midrst_mem_valid", mem_valid, 1'b0);
            chk("midrst_wb_regwrite", wb_regwrite, 1'b0);
        end
        drive(1'b0, 1'b1, C_RW, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        chk("post_rst_ex_valid", ex_valid, 1'b1);
        chk("post_rst_ex_rd", ex_rd, 5'd3);
        chk("post_rst_mem_valid", mem_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
